gshare_predictor: RTL and testbench

//  Parametrised direction predictor for the fetch stage: bimodal or gshare pattern-history table (PHT)
//  of CNT_BITS saturating counters plus a speculative global history register (GHR) with ROB-driven recovery.

---
 rtl/gshare_predictor_pkg.sv | 9 +
 rtl/gshare_predictor_pht.sv | 56 +++++
 rtl/gshare_predictor.sv | 157 +++++++++++++++
 tb/tb_gshare_predictor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared constants for the gshare/bimodal direction predictor.
package gshare_predictor_pkg;
  localparam int ADDR_WIDTH        = 32;
  localparam int PRED_MODE_BIMODAL = 0;
  localparam int PRED_MODE_GSHARE  = 1;

  localparam logic [0:0] PRED_ST_INIT = 1'b0;
  localparam logic [0:0] PRED_ST_RUN  = 1'b1;
endpackage

// File: rtl/gshare_predictor_pht.sv
// Pattern-history table: counter array with one write port, a bypassed
// predict read (registered MSB) and a raw read for the commit update.
module gshare_predictor_pht #(
  parameter int IDX_BITS = 8,
  parameter int CNT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_in,
  input  logic [IDX_BITS-1:0] wr_idx_in,
  input  logic [CNT_BITS-1:0] wr_cnt_in,
  input  logic                rd_en_in,
  input  logic [IDX_BITS-1:0] rd_idx_in,
  output logic [CNT_BITS-1:0] rd_cnt_out,
  output logic                rd_taken_out,
  input  logic [IDX_BITS-1:0] upd_idx_in,
  output logic [CNT_BITS-1:0] upd_cnt_out
);
  localparam int DEPTH = 1 << IDX_BITS;

  logic [CNT_BITS-1:0] mem_q [DEPTH];
  logic                rd_taken_q;
  logic                rd_taken_d;

  // Write-first: a same-cycle update to the predicted entry is visible to the read.
  always_comb begin
    rd_cnt_out = mem_q[rd_idx_in];
    if (wr_en_in && (wr_idx_in == rd_idx_in)) begin
      rd_cnt_out = wr_cnt_in;
    end
  end

  always_comb begin
    rd_taken_d = rd_taken_q;
    if (rd_en_in) begin
      rd_taken_d = rd_cnt_out[CNT_BITS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_in) begin
      mem_q[wr_idx_in] <= wr_cnt_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_taken_q <= 1'b0;
    end else begin
      rd_taken_q <= rd_taken_d;
    end
  end

  assign upd_cnt_out  = mem_q[upd_idx_in];
  assign rd_taken_out = rd_taken_q;
endmodule

// File: rtl/gshare_predictor.sv
// Fetch-stage direction predictor: PHT init sequencer, speculative GHR with
// ROB-driven mispredict recovery, index hashing and counter saturation.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int CNT_BITS = 2,
  parameter int GHR_LEN  = 8,
  parameter int MODE     = PRED_MODE_GSHARE
) (
  input  logic                  clk,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  pred_req_in,
  input  logic [ADDR_WIDTH-1:0] pred_pc_in,
  output logic                  pred_valid_out,
  output logic                  pred_jump_out,
  output logic [GHR_LEN-1:0]    pred_ghr_out,
  output logic                  ready_out,
  input  logic                  upd_en_in,
  input  logic [ADDR_WIDTH-1:0] upd_pc_in,
  input  logic [GHR_LEN-1:0]    upd_ghr_in,
  input  logic                  upd_jump_in,
  input  logic                  upd_mispred_in
);
  localparam logic [CNT_BITS-1:0] INIT_VAL = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  function automatic logic [IDX_BITS-1:0] hash_idx(input logic [IDX_BITS-1:0] base,
                                                   input logic [GHR_LEN-1:0]  hist);
    logic [IDX_BITS-1:0] mix;
    mix = (MODE == PRED_MODE_GSHARE) ? IDX_BITS'(hist) : '0;
    return base ^ mix;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_step(input logic [CNT_BITS-1:0] cnt,
                                                   input logic                up);
    if (up) begin
      return (cnt == '1) ? cnt : cnt + CNT_BITS'(1);
    end
    return (cnt == '0) ? cnt : cnt - CNT_BITS'(1);
  endfunction

  // Truncating cast keeps this legal for a one-bit history.
  function automatic logic [GHR_LEN-1:0] shift_in(input logic [GHR_LEN-1:0] hist,
                                                  input logic               b);
    return GHR_LEN'({hist, b});
  endfunction

  logic [0:0]          state_q, state_d;
  logic [IDX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic                ready_q, ready_d;
  logic [GHR_LEN-1:0]  ghr_q, ghr_d;
  logic                pred_valid_q, pred_valid_d;
  logic [GHR_LEN-1:0]  pred_ghr_q, pred_ghr_d;

  logic                pht_we;
  logic [IDX_BITS-1:0] pht_wr_idx;
  logic [CNT_BITS-1:0] pht_wr_cnt;
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [CNT_BITS-1:0] pred_cnt;
  logic [CNT_BITS-1:0] upd_cnt;
  logic                pred_fire;
  logic                run_rdy;
  logic                unused_bits;

  assign run_rdy   = rdy_in && (state_q == PRED_ST_RUN);
  assign pred_fire = run_rdy && pred_req_in;
  assign pred_idx  = hash_idx(pred_pc_in[IDX_BITS+1:2], ghr_q);
  assign upd_idx   = hash_idx(upd_pc_in[IDX_BITS+1:2], upd_ghr_in);

  always_comb begin
    pht_we     = 1'b0;
    pht_wr_idx = init_ptr_q;
    pht_wr_cnt = INIT_VAL;
    if (rdy_in) begin
      if (state_q == PRED_ST_INIT) begin
        pht_we = 1'b1;
      end else if (upd_en_in) begin
        pht_we     = 1'b1;
        pht_wr_idx = upd_idx;
        pht_wr_cnt = sat_step(upd_cnt, upd_jump_in);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    ready_d      = ready_q;
    ghr_d        = ghr_q;
    pred_valid_d = pred_valid_q;
    pred_ghr_d   = pred_ghr_q;
    if (rdy_in) begin
      if (state_q == PRED_ST_INIT) begin
        init_ptr_d = init_ptr_q + IDX_BITS'(1);
        if (init_ptr_q == LAST_IDX) begin
          state_d = PRED_ST_RUN;
          ready_d = 1'b1;
        end
      end else begin
        pred_valid_d = pred_req_in;
        if (pred_req_in) begin
          pred_ghr_d = ghr_q;
          ghr_d      = shift_in(ghr_q, pred_cnt[CNT_BITS-1]);
        end
        // Recovery wins over the speculative shift of a same-cycle prediction.
        if (upd_en_in && upd_mispred_in) begin
          ghr_d = shift_in(upd_ghr_in, upd_jump_in);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= PRED_ST_INIT;
      init_ptr_q   <= '0;
      ready_q      <= 1'b0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_ghr_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      ready_q      <= ready_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_ghr_q   <= pred_ghr_d;
    end
  end

  gshare_predictor_pht #(
    .IDX_BITS (IDX_BITS),
    .CNT_BITS (CNT_BITS)
  ) u_pred_pht (
    .clk          (clk),
    .rst_n        (rst_n_in),
    .wr_en_in     (pht_we),
    .wr_idx_in    (pht_wr_idx),
    .wr_cnt_in    (pht_wr_cnt),
    .rd_en_in     (pred_fire),
    .rd_idx_in    (pred_idx),
    .rd_cnt_out   (pred_cnt),
    .rd_taken_out (pred_jump_out),
    .upd_idx_in   (upd_idx),
    .upd_cnt_out  (upd_cnt)
  );

  assign unused_bits = ^{pred_pc_in[ADDR_WIDTH-1:IDX_BITS+2], pred_pc_in[1:0],
                         upd_pc_in[ADDR_WIDTH-1:IDX_BITS+2], upd_pc_in[1:0], pred_cnt};

  assign pred_valid_out = pred_valid_q;
  assign pred_ghr_out   = pred_ghr_q;
  assign ready_out      = ready_q;
endmodule

// File: tb/tb_gshare_predictor.sv
// Randomised + directed bench: a bimodal and a gshare instance share stimulus
// and are each compared every cycle against an array-based reference model.
module tb_gshare_predictor;
  import gshare_predictor_pkg::*;

  localparam int IDX  = 8;
  localparam int CNT  = 2;
  localparam int GL   = 8;
  localparam int N    = 1 << IDX;
  localparam int CMAX = (1 << CNT) - 1;
  localparam int CTHR = 1 << (CNT - 1);
  localparam int CINI = CTHR - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, rdy, req, upd_en, upd_jump, upd_mis;
  logic [ADDR_WIDTH-1:0] pc, upd_pc;
  logic [GL-1:0]         upd_ghr;
  logic [1:0]            pv, pj, rdyo;
  logic [1:0][GL-1:0]    pg;

  gshare_predictor #(.IDX_BITS(IDX), .CNT_BITS(CNT), .GHR_LEN(GL), .MODE(PRED_MODE_BIMODAL)) dut0 (
    .clk(clk), .rst_n_in(rst_n), .rdy_in(rdy), .pred_req_in(req), .pred_pc_in(pc),
    .pred_valid_out(pv[0]), .pred_jump_out(pj[0]), .pred_ghr_out(pg[0]), .ready_out(rdyo[0]),
    .upd_en_in(upd_en), .upd_pc_in(upd_pc), .upd_ghr_in(upd_ghr), .upd_jump_in(upd_jump),
    .upd_mispred_in(upd_mis));

  gshare_predictor #(.IDX_BITS(IDX), .CNT_BITS(CNT), .GHR_LEN(GL), .MODE(PRED_MODE_GSHARE)) dut1 (
    .clk(clk), .rst_n_in(rst_n), .rdy_in(rdy), .pred_req_in(req), .pred_pc_in(pc),
    .pred_valid_out(pv[1]), .pred_jump_out(pj[1]), .pred_ghr_out(pg[1]), .ready_out(rdyo[1]),
    .upd_en_in(upd_en), .upd_pc_in(upd_pc), .upd_ghr_in(upd_ghr), .upd_jump_in(upd_jump),
    .upd_mispred_in(upd_mis));

  int m_pht [2][N];
  int m_ghr [2];
  bit e_valid [2];
  bit e_jump [2];
  int e_ghr [2];
  int m_initcnt;
  bit m_ready;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ghr[m] = 0; e_valid[m] = 0; e_jump[m] = 0; e_ghr[m] = 0;
      for (int i = 0; i < N; i++) m_pht[m][i] = -1;
    end
    m_initcnt = 0;
    m_ready   = 0;
  endfunction

  function automatic void model_edge();
    int iu, ip, c, ng;
    bit t;
    if (!rdy) return;
    if (!m_ready) begin
      for (int m = 0; m < 2; m++) m_pht[m][m_initcnt] = CINI;
      m_initcnt++;
      if (m_initcnt == N) m_ready = 1;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (upd_en) begin
        iu = ((upd_pc >> 2) % N) ^ (m == 1 ? int'(upd_ghr) : 0);
        c  = m_pht[m][iu] + (upd_jump ? 1 : -1);
        if (c < 0) c = 0;
        if (c > CMAX) c = CMAX;
        m_pht[m][iu] = c;
      end
      ng = m_ghr[m];
      e_valid[m] = req;
      if (req) begin
        ip = ((pc >> 2) % N) ^ (m == 1 ? m_ghr[m] : 0);
        t  = (m_pht[m][ip] >= CTHR);
        e_jump[m] = t;
        e_ghr[m]  = m_ghr[m];
        ng = ((m_ghr[m] * 2) + int'(t)) % (1 << GL);
      end
      if (upd_en && upd_mis) ng = ((int'(upd_ghr) * 2) + int'(upd_jump)) % (1 << GL);
      m_ghr[m] = ng;
    end
  endfunction

  task automatic check_outs();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("ready_m%0d", m), rdyo[m], m_ready);
      chk($sformatf("valid_m%0d", m), pv[m], e_valid[m]);
      if (e_valid[m]) begin
        chk($sformatf("jump_m%0d", m), pj[m], e_jump[m]);
        chk($sformatf("ghr_m%0d", m), pg[m], e_ghr[m]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic idle();
    rdy = 1; req = 0; upd_en = 0; upd_mis = 0; upd_jump = 0;
  endtask

  task automatic do_update(input int a, input bit j);
    idle(); upd_en = 1; upd_pc = a; upd_jump = j; upd_ghr = '0;
    step();
    idle();
  endtask

  task automatic do_predict(input int a);
    idle(); req = 1; pc = a;
    step();
    idle();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    chk("rst_valid", pv, 2'b00);
    chk("rst_jump", pj, 2'b00);
    chk("rst_ghr", pg, '0);
    chk("rst_ready", rdyo, 2'b00);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic rand_inputs(input int rdy_pct);
    rdy      = ($urandom_range(0, 99) < rdy_pct);
    req      = $urandom_range(0, 1);
    pc       = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
    upd_en   = ($urandom_range(0, 9) < 4);
    upd_pc   = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
    upd_jump = $urandom_range(0, 1);
    upd_mis  = ($urandom_range(0, 9) < 3);
    upd_ghr  = GL'($urandom);
  endtask

  task automatic run_init();
    int n_rdy = 0;
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      rand_inputs(80);
      step();
      if (rdy) n_rdy++;
      if (rdyo == 2'b11) done = 1;
    end
    chk("init_ready_cycles", n_rdy, N);
    idle();
  endtask

  initial begin
    bit [GL-1:0] held;
    idle(); pc = '0; upd_pc = '0; upd_ghr = '0;
    do_reset();
    run_init();

    // GHR snapshots from a fresh gshare table
    do_predict(32'h0);  chk("t3_snap0", pg[1], 8'h00); chk("t3_nt0", pj[1], 1'b0);
    do_predict(32'h4);  chk("t3_snap1", pg[1], 8'h00);
    do_update(32'h0, 1'b1);
    do_predict(32'h0);  chk("t3_taken", pj[1], 1'b1);
    do_predict(32'h40); chk("t3_snap2", pg[1], 8'h01);

    // bimodal counter walk at pc 0x100
    do_update(32'h100, 1'b1); do_update(32'h100, 1'b1);
    do_predict(32'h100); chk("t2_taken", pj[0], 1'b1);
    for (int i = 0; i < 4; i++) do_update(32'h100, 1'b0);
    do_predict(32'h100); chk("t2_nt", pj[0], 1'b0);
    do_update(32'h100, 1'b1); do_update(32'h100, 1'b1);
    do_predict(32'h100); chk("t2_floor", pj[0], 1'b1);

    // upper saturation at pc 0x300
    for (int i = 0; i < 3; i++) do_update(32'h300, 1'b1);
    do_update(32'h300, 1'b0); do_update(32'h300, 1'b0);
    do_predict(32'h300); chk("sat_ceiling", pj[0], 1'b0);

    // mispredict recovery with a same-cycle request
    idle(); req = 1; pc = 32'h800; upd_en = 1; upd_mis = 1; upd_jump = 1;
    upd_pc = 32'h900; upd_ghr = 8'h5A;
    step();
    chk("t4_pulse0", pv[0], 1'b1); chk("t4_pulse1", pv[1], 1'b1);
    do_predict(32'h804); chk("t4_ghr0", pg[0], 8'hB5); chk("t4_ghr1", pg[1], 8'hB5);

    // write-first bypass on a fresh bimodal entry
    idle(); req = 1; pc = 32'h200; upd_en = 1; upd_pc = 32'h200; upd_jump = 1;
    step();
    chk("t5_bypass", pj[0], 1'b1);

    // freeze with a request held
    idle(); req = 1; pc = 32'h104;
    step();
    held = pg[1];
    rdy = 0; upd_en = 1; upd_mis = 1; upd_ghr = 8'hFF; pc = 32'h108;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_hold_valid", pv[1], 1'b1);
      chk("t6_hold_ghr", pg[1], held);
    end
    idle();
    step();
    chk("t6_drop", pv, 2'b00);

    for (int i = 0; i < 3000; i++) begin
      rand_inputs(90);
      step();
    end

    // mid-run reset
    idle();
    do_reset();
    run_init();
    do_predict(32'h100); chk("post_rst_nt0", pj[0], 1'b0);
    do_predict(32'h300); chk("post_rst_nt1", pj[1], 1'b0);
    for (int i = 0; i < 500; i++) begin
      rand_inputs(90);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
